mem_access_unit: RTL and testbench

//   Bus initiator between the CPU load/store stage and the word-organised data memory.

---
 rtl/mem_access_unit.sv | 207 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Bus initiator between the CPU load/store stage and a 16-bit word-organised
//   data memory. A byte-addressed request is latched on acceptance, turned into
//   one memory access (word address + byte lane), and answered with a single
//   one-cycle response. Byte loads are sign- or zero-extended. Misaligned word
//   accesses and memory-wait timeouts complete with resp_err set.
//
// Ports
//   clk, rst_n                   clock, synchronous active-low reset
//   req_valid/req_ready          request handshake (ready only while idle)
//   req_write/byte/signed        access kind
//   req_addr, req_wdata          byte address, store data
//   resp_valid/err/rdata         one-cycle completion pulse, error flag, load data
//   mem_en/we/byte_enable/
//   mem_byte_select/addr/wdata   memory access, driven from the latched request
//   mem_rdata, mem_wait          read data (cycle after mem_en), stall
module mem_access_unit #(
  parameter int unsigned WAIT_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic        req_signed,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [15:0] resp_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic        mem_byte_enable,
  output logic        mem_byte_select,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_wait
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_RESP} state_e;

  localparam logic [8:0] TimeoutLimit = 9'(WAIT_TIMEOUT);
  localparam bit         TimeoutOn    = (WAIT_TIMEOUT != 0);

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic        byte_q, byte_d;
  logic        signed_q, signed_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [15:0] resp_rdata_q, resp_rdata_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_we_q, mem_we_d;
  logic        mem_be_q, mem_be_d;
  logic        mem_sel_q, mem_sel_d;

  logic [8:0]  wait_cnt_inc;
  logic [7:0]  wait_cnt_sat;
  logic        wait_hit;
  logic [15:0] load_data;

  // The current stall cycle is counted before comparing, so the abort happens
  // on the WAIT_TIMEOUT-th consecutive wait cycle rather than one later.
  assign wait_cnt_inc = {1'b0, wait_cnt_q} + 9'd1;
  assign wait_cnt_sat = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;
  assign wait_hit     = TimeoutOn && (wait_cnt_inc >= TimeoutLimit);

  // The memory returns byte reads right-aligned and zero-filled, so only
  // bit 7 matters for sign extension regardless of the lane.
  assign load_data = byte_q ? {{8{signed_q & mem_rdata[7]}}, mem_rdata[7:0]} : mem_rdata;

  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    byte_d       = byte_q;
    signed_d     = signed_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wait_cnt_d   = 8'd0;
    req_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 16'h0000;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_be_d     = 1'b0;
    mem_sel_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          write_d     = req_write;
          byte_d      = req_byte;
          signed_d    = req_signed;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          req_ready_d = 1'b0;
          if (!req_byte && req_addr[0]) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d   = S_ISSUE;
            mem_en_d  = 1'b1;
            mem_we_d  = req_write;
            mem_be_d  = req_byte;
            mem_sel_d = req_addr[0];
          end
        end
      end
      S_ISSUE: begin
        if (mem_wait) begin
          if (wait_hit) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            mem_en_d   = 1'b1;
            mem_we_d   = write_q;
            mem_be_d   = byte_q;
            mem_sel_d  = addr_q[0];
            wait_cnt_d = wait_cnt_sat;
          end
        end else if (write_q) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
        end else begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (mem_wait) begin
          if (wait_hit) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_sat;
          end
        end else begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = load_data;
        end
      end
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      write_q      <= 1'b0;
      byte_q       <= 1'b0;
      signed_q     <= 1'b0;
      addr_q       <= 16'h0000;
      wdata_q      <= 16'h0000;
      wait_cnt_q   <= 8'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 16'h0000;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= 1'b0;
      mem_sel_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      byte_q       <= byte_d;
      signed_q     <= signed_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wait_cnt_q   <= wait_cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_be_q     <= mem_be_d;
      mem_sel_q    <= mem_sel_d;
    end
  end

  assign req_ready       = req_ready_q;
  assign resp_valid      = resp_valid_q;
  assign resp_err        = resp_err_q;
  assign resp_rdata      = resp_rdata_q;
  assign mem_en          = mem_en_q;
  assign mem_we          = mem_we_q;
  assign mem_byte_enable = mem_be_q;
  assign mem_byte_select = mem_sel_q;
  assign mem_addr        = {1'b0, addr_q[15:1]};
  assign mem_wdata       = byte_q ? {8'h00, wdata_q[7:0]} : wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: a word memory with programmable stall
// lengths answers the DUT; a reference model predicts every memory access and
// every response, and two monitors compare them as the DUT produces them.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic        req_byte = 1'b0;
  logic        req_signed = 1'b0;
  logic [15:0] req_addr = 16'h0;
  logic [15:0] req_wdata = 16'h0;
  logic        resp_valid;
  logic        resp_err;
  logic [15:0] resp_rdata;
  logic        mem_en;
  logic        mem_we;
  logic        mem_byte_enable;
  logic        mem_byte_select;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'h0;
  logic        mem_wait = 1'b0;

  always #5 clk = ~clk;

  mem_access_unit #(.WAIT_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_byte(req_byte), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_byte_enable(mem_byte_enable),
    .mem_byte_select(mem_byte_select), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_wait(mem_wait)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ntx = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- memory responder ----------------
  logic [15:0] mem [64];
  logic [15:0] ref_mem [64];
  logic        cap_phase = 1'b0;
  int cfg_iw = 0, cfg_cw = 0;
  int iss_cnt = 0, cap_cnt = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      cap_phase <= 1'b0;
    end else if (mem_en && !mem_wait) begin
      if (mem_we) begin
        if (!mem_byte_enable) mem[int'(mem_addr) % 64] <= mem_wdata;
        else if (mem_byte_select) mem[int'(mem_addr) % 64][15:8] <= mem_wdata[7:0];
        else mem[int'(mem_addr) % 64][7:0] <= mem_wdata[7:0];
        cap_phase <= 1'b0;
      end else begin
        if (!mem_byte_enable) mem_rdata <= mem[int'(mem_addr) % 64];
        else if (mem_byte_select) mem_rdata <= {8'h00, mem[int'(mem_addr) % 64][15:8]};
        else mem_rdata <= {8'h00, mem[int'(mem_addr) % 64][7:0]};
        cap_phase <= 1'b1;
      end
    end else if (!mem_wait) begin
      cap_phase <= 1'b0;
    end
  end

  // Stall the access phase for cfg_iw cycles and the data phase for cfg_cw.
  always @(negedge clk) begin
    if (mem_en) begin
      cap_cnt = 0;
      if (iss_cnt < cfg_iw) begin mem_wait = 1'b1; iss_cnt++; end
      else mem_wait = 1'b0;
    end else begin
      iss_cnt = 0;
      if (cap_phase && cap_cnt < cfg_cw) begin mem_wait = 1'b1; cap_cnt++; end
      else mem_wait = 1'b0;
      if (!cap_phase) cap_cnt = 0;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct { logic err; logic [15:0] rdata; int cyc; } resp_t;
  typedef struct { logic [34:0] sig; int n; } acc_t;
  resp_t resp_q[$];
  acc_t  acc_q[$];
  resp_t mon_r;
  int    en_run = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (resp_valid) begin
        if (resp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp: actual=resp_valid high required=no pending request (cycle %0d)", cyc);
        end else begin
          mon_r = resp_q.pop_front();
          check("resp_err", 64'(resp_err), 64'(mon_r.err));
          check("resp_rdata", 64'(resp_rdata), 64'(mon_r.rdata));
          check("resp_cycle", 64'(cyc), 64'(mon_r.cyc));
          ntx++;
          $display("txn %0d: err=%0b rdata=%h cycle=%0d", ntx, resp_err, resp_rdata, cyc);
        end
      end
      if (mem_en) begin
        if (acc_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_mem_en: actual=mem_en high addr=%h required=no access pending", mem_addr);
        end else begin
          check("mem_fields", 64'({mem_we, mem_byte_enable, mem_byte_select, mem_addr, mem_wdata}),
                64'(acc_q[0].sig));
          en_run++;
        end
      end else if (en_run > 0) begin
        if (acc_q.size() > 0) begin
          check("mem_en_cycles", 64'(en_run), 64'(acc_q[0].n));
          void'(acc_q.pop_front());
        end
        en_run = 0;
      end
    end
  end

  // ---------------- driver + reference model ----------------
  // Entered at a negedge. Returns at a negedge after acceptance.
  task automatic issue(input logic w, input logic b, input logic s, input logic [15:0] a,
                       input logic [15:0] wd, input int iw, input int cw, input bit busy);
    int guard;
    int idx;
    resp_t r;
    acc_t m;
    logic [15:0] word;
    logic [7:0] bv;
    req_write = w; req_byte = b; req_signed = s; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    guard = 0;
    while (!req_ready && guard < 100) begin @(negedge clk); guard++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: actual=req_ready low for 100 cycles required=high");
      req_valid = 1'b0;
      return;
    end
    cfg_iw = iw; cfg_cw = cw;
    idx = (int'(a) / 2) % 64;
    r.err = 1'b0; r.rdata = 16'h0;
    if (!b && a[0]) begin
      r.err = 1'b1; r.cyc = cyc + 1;
    end else begin
      m.sig = {w, b, a[0], a / 16'd2, b ? {8'h00, wd[7:0]} : wd};
      if (iw >= TO) begin
        m.n = TO; r.err = 1'b1; r.cyc = cyc + 1 + TO;
      end else begin
        m.n = iw + 1;
        if (w) begin
          if (!b) ref_mem[idx] = wd;
          else if (a[0]) ref_mem[idx][15:8] = wd[7:0];
          else ref_mem[idx][7:0] = wd[7:0];
          r.cyc = cyc + 2 + iw;
        end else if (cw >= TO) begin
          r.err = 1'b1; r.cyc = cyc + 2 + iw + TO;
        end else begin
          word = ref_mem[idx];
          bv = a[0] ? word[15:8] : word[7:0];
          if (!b) r.rdata = word;
          else if (s) r.rdata = 16'($signed(bv));
          else r.rdata = {8'h00, bv};
          r.cyc = cyc + 3 + iw + cw;
        end
      end
      acc_q.push_back(m);
    end
    resp_q.push_back(r);
    @(negedge clk);
    if (busy) begin
      // A request while busy must be ignored, not queued.
      req_write = 1'b1; req_byte = 1'b0; req_addr = 16'h0040; req_wdata = 16'hDEAD;
      @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: actual=simulation still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int gap, iw, cw, k, guard;
    for (int i = 0; i < 64; i++) begin
      mem[i] = 16'($urandom);
      ref_mem[i] = mem[i];
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_req_ready", 64'(req_ready), 64'd1);
    check("reset_resp", 64'({resp_valid, resp_err, resp_rdata}), 64'd0);
    check("reset_mem_ctl", 64'({mem_en, mem_we, mem_byte_enable, mem_byte_select}), 64'd0);
    check("reset_mem_bus", 64'({mem_addr, mem_wdata}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(1, 0, 0, 16'h0004, 16'hBEEF, 0, 0, 0);
    issue(0, 0, 0, 16'h0004, 16'h0000, 0, 0, 0);
    issue(1, 0, 0, 16'h0004, 16'h80FF, 0, 0, 0);
    issue(0, 1, 1, 16'h0005, 16'h0000, 0, 0, 0);
    issue(0, 1, 0, 16'h0005, 16'h0000, 0, 0, 1);
    issue(1, 1, 0, 16'h0007, 16'h12AB, 0, 0, 0);
    issue(0, 0, 0, 16'h0006, 16'h0000, 0, 0, 0);
    issue(1, 0, 0, 16'h0003, 16'h5555, 0, 0, 1);
    issue(0, 0, 0, 16'h0004, 16'h0000, 3, 0, 0);
    issue(0, 0, 0, 16'h0006, 16'h0000, 0, 3, 0);
    issue(1, 0, 0, 16'h0008, 16'h1234, 6, 0, 0);
    issue(0, 1, 1, 16'h0009, 16'h0000, 0, 5, 0);
    issue(0, 0, 0, 16'h0008, 16'h0000, 0, 0, 0);

    // Reset while the load sits in its data phase.
    guard = 0;
    while (!req_ready && guard < 100) begin @(negedge clk); guard++; end
    cfg_iw = 0; cfg_cw = 3;
    req_write = 1'b0; req_byte = 1'b0; req_signed = 1'b0; req_addr = 16'h000A; req_valid = 1'b1;
    acc_q.push_back('{sig: {1'b0, 1'b0, 1'b0, 16'h0005, 16'h0000}, n: 1});
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset_req_ready", 64'(req_ready), 64'd1);
    check("midreset_resp_valid", 64'(resp_valid), 64'd0);
    check("midreset_mem_en", 64'(mem_en), 64'd0);
    repeat (6) @(negedge clk);
    issue(0, 0, 0, 16'h000A, 16'h0000, 0, 0, 0);

    for (int t = 0; t < 150; t++) begin
      k = $urandom_range(0, 9);
      iw = (k < 6) ? 0 : (k < 9) ? $urandom_range(1, 3) : $urandom_range(4, 5);
      k = $urandom_range(0, 9);
      cw = (k < 6) ? 0 : (k < 9) ? $urandom_range(1, 3) : $urandom_range(4, 5);
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            16'($urandom_range(0, 127)), 16'($urandom), iw, cw, 1'($urandom_range(0, 1)));
    end

    guard = 0;
    while ((resp_q.size() != 0 || acc_q.size() != 0 || en_run != 0) && guard < 200) begin
      @(negedge clk); guard++;
    end
    repeat (3) @(negedge clk);
    check("resp_queue_drained", 64'(resp_q.size()), 64'd0);
    check("acc_queue_drained", 64'(acc_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
